// File: rtl/pc_gen_pkg.sv
// Shared definitions for the PC generator: FSM state encoding, sequential step
// and the instruction-alignment helper.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam int PC_STEP = 4;

  // Number of low target bits that must be zero: 2 for IALIGN=32, 1 for IALIGN=16.
  function automatic int align_bits(input int ialign);
    return (ialign == 16) ? 1 : 2;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Control and status bundle between the fetch-side PC generator and its driver.
interface pc_gen_if #(parameter int XLEN = 32);
  logic            en;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vec;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            pc_valid;
  logic            misalign_err;
  logic [XLEN-1:0] misalign_addr;

  modport master (
    output en, redirect_valid, redirect_pc, trap_valid, trap_vec,
    input  pc, pc_plus4, pc_valid, misalign_err, misalign_addr
  );

  modport slave (
    input  en, redirect_valid, redirect_pc, trap_valid, trap_vec,
    output pc, pc_plus4, pc_valid, misalign_err, misalign_addr
  );
endinterface

// File: rtl/pc_redirect_buf.sv
// Holds one redirect target taken during a stall; a newer target overwrites
// the held one, and clear wins over set so a same-cycle trap discards it.
module pc_redirect_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_set,
  input  logic [XLEN-1:0] i_set_pc,
  input  logic            i_clr,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_set) begin
      r_valid <= 1'b1;
      r_pc    <= i_set_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: boot sequencing, trap/redirect/sequential priority mux,
// stall-time redirect buffering and misaligned-target halt.
//   state   | meaning
//   ST_BOOT | first cycle after reset, pc = RESET_VEC, not yet valid
//   ST_RUN  | fetching, pc_valid = 1
//   ST_HALT | misaligned target rejected, waiting for a trap
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              IALIGN    = 32
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.slave bus
);

  localparam int              ALIGN_BITS = align_bits(IALIGN);
  localparam logic [XLEN-1:0] LOW_MASK   = {{(XLEN-ALIGN_BITS){1'b0}}, {ALIGN_BITS{1'b1}}};

  state_e          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_err;
  logic [XLEN-1:0] r_maddr;

  state_e          w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic            w_err_nxt;
  logic [XLEN-1:0] w_maddr_nxt;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_pend_set;
  logic            w_pend_clr;
  logic            w_pend_valid;
  logic [XLEN-1:0] w_pend_pc;
  logic            w_apply;
  logic [XLEN-1:0] w_tgt;

  assign w_pc_plus4 = r_pc + XLEN'(PC_STEP);

  pc_redirect_buf #(.XLEN(XLEN)) u_redirect_buf (
    .clk      (clk),
    .rst      (rst),
    .i_set    (w_pend_set),
    .i_set_pc (bus.redirect_pc),
    .i_clr    (w_pend_clr),
    .o_valid  (w_pend_valid),
    .o_pc     (w_pend_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_VEC;
      r_err   <= 1'b0;
      r_maddr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_err   <= w_err_nxt;
      r_maddr <= w_maddr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_err_nxt   = 1'b0;
    w_maddr_nxt = r_maddr;
    w_pend_set  = 1'b0;
    w_pend_clr  = 1'b0;
    w_apply     = 1'b0;
    w_tgt       = r_pc;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (bus.trap_valid) begin
          w_pc_nxt   = bus.trap_vec & ~LOW_MASK;
          w_pend_clr = 1'b1;
        end else if (bus.redirect_valid && bus.en) begin
          w_apply = 1'b1;
          w_tgt   = bus.redirect_pc;
        end else if (bus.redirect_valid) begin
          w_pend_set = 1'b1;
        end else if (w_pend_valid && bus.en) begin
          w_apply = 1'b1;
          w_tgt   = w_pend_pc;
        end else if (bus.en) begin
          w_pc_nxt = w_pc_plus4;
        end
        // Every applied target drops the buffer; a bad one halts instead of loading.
        if (w_apply) begin
          w_pend_clr = 1'b1;
          if ((w_tgt & LOW_MASK) != '0) begin
            w_err_nxt   = 1'b1;
            w_maddr_nxt = w_tgt;
            w_state_nxt = ST_HALT;
          end else begin
            w_pc_nxt = w_tgt;
          end
        end
      end
      ST_HALT: begin
        if (bus.trap_valid) begin
          w_pc_nxt    = bus.trap_vec & ~LOW_MASK;
          w_pend_clr  = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  always_comb begin
    bus.pc            = r_pc;
    bus.pc_plus4      = w_pc_plus4;
    bus.pc_valid      = (r_state == ST_RUN);
    bus.misalign_err  = r_err;
    bus.misalign_addr = r_maddr;
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: one DUT per alignment setting, both driven
// identically and compared against a cycle-level behavioural model.
module tb_pc_gen;

  typedef struct {
    logic [31:0] pc;
    bit          boot;
    bit          halt;
    bit          pend;
    logic [31:0] pend_pc;
    bit          err;
    logic [31:0] maddr;
  } mdl_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        rv = 1'b0;
  logic [31:0] rpc = '0;
  logic        tv = 1'b0;
  logic [31:0] tvec = '0;

  int   n_checks = 0;
  int   n_fails  = 0;
  mdl_t m32;
  mdl_t m16;

  pc_gen_if #(.XLEN(32)) b32 ();
  pc_gen_if #(.XLEN(32)) b16 ();

  assign b32.en = en;  assign b32.redirect_valid = rv;  assign b32.redirect_pc = rpc;
  assign b32.trap_valid = tv;  assign b32.trap_vec = tvec;
  assign b16.en = en;  assign b16.redirect_valid = rv;  assign b16.redirect_pc = rpc;
  assign b16.trap_valid = tv;  assign b16.trap_vec = tvec;

  pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .IALIGN(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .IALIGN(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

  always #5 clk = ~clk;

  function automatic mdl_t mstep(mdl_t s, int ab, bit r, bit e, bit rvalid,
                                 logic [31:0] rtgt, bit tvalid, logic [31:0] tv_addr);
    mdl_t        n = s;
    logic [31:0] lowmask = (32'd1 << ab) - 32'd1;
    logic [31:0] tgt = '0;
    bit          apply = 0;
    n.err = 0;
    if (r) begin
      n.pc = 32'h0; n.boot = 1; n.halt = 0; n.pend = 0; n.pend_pc = 0; n.maddr = 0;
      return n;
    end
    if (s.boot) begin n.boot = 0; return n; end
    if (tvalid) begin n.pc = tv_addr & ~lowmask; n.pend = 0; n.halt = 0; return n; end
    if (s.halt) return n;
    if (rvalid && e) begin tgt = rtgt; apply = 1; end
    else if (rvalid) begin n.pend = 1; n.pend_pc = rtgt; end
    else if (s.pend && e) begin tgt = s.pend_pc; apply = 1; end
    else if (e) n.pc = s.pc + 32'd4;
    if (apply) begin
      n.pend = 0;
      if ((tgt & lowmask) != 0) begin n.err = 1; n.maddr = tgt; n.halt = 1; end
      else n.pc = tgt;
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    m32 = mstep(m32, 2, rst, en, rv, rpc, tv, tvec);
    m16 = mstep(m16, 1, rst, en, rv, rpc, tv, tvec);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; en = 1; rv = 0; tv = 0;
    tick(); tick();
    n_checks++; if (b32.pc !== 32'h0) begin n_fails++; $display("FAIL reset_pc got %h want %h", b32.pc, 32'h0); end
    n_checks++; if (b32.pc_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid got %b want 0", b32.pc_valid); end
    n_checks++; if (b32.misalign_err !== 1'b0 || b32.misalign_addr !== 32'h0) begin
      n_fails++; $display("FAIL reset_misalign got %b/%h want 0/0", b32.misalign_err, b32.misalign_addr); end
    rst = 0;
    tick();
    n_checks++; if (b32.pc_valid !== 1'b1 || b32.pc !== 32'h0) begin
      n_fails++; $display("FAIL boot_first got %b/%h want 1/0", b32.pc_valid, b32.pc); end
    for (int i = 1; i <= 2; i++) begin
      tick();
      n_checks++; if (b32.pc !== 32'(4 * i) || b16.pc !== m16.pc) begin
        n_fails++; $display("FAIL boot_seq got %h/%h want %h", b32.pc, b16.pc, 32'(4 * i)); end
    end
  endtask

  task automatic test_stall_wrap();
    en = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (b32.pc !== 32'h8) begin n_fails++; $display("FAIL stall_hold got %h want 8", b32.pc); end
    end
    en = 1; rv = 1; rpc = 32'hFFFF_FFFC;
    tick();
    rv = 0;
    n_checks++; if (b32.pc !== 32'hFFFF_FFFC || b32.pc_plus4 !== 32'h0) begin
      n_fails++; $display("FAIL wrap_pre got %h/%h want fffffffc/0", b32.pc, b32.pc_plus4); end
    tick();
    n_checks++; if (b32.pc !== 32'h0 || b32.misalign_err !== 1'b0) begin
      n_fails++; $display("FAIL wrap got %h err %b want 0 err 0", b32.pc, b32.misalign_err); end
  endtask

  task automatic test_redirect_stall();
    logic [31:0] held;
    held = b32.pc;
    en = 0; rv = 1; rpc = 32'h100; tick();
    rpc = 32'h200; tick();
    rv = 0; tick(); tick();
    n_checks++; if (b32.pc !== held) begin n_fails++; $display("FAIL pend_hold got %h want %h", b32.pc, held); end
    en = 1; tick();
    n_checks++; if (b32.pc !== 32'h200 || b16.pc !== 32'h200) begin
      n_fails++; $display("FAIL pend_last_wins got %h/%h want 200", b32.pc, b16.pc); end
    tick();
    n_checks++; if (b32.pc !== 32'h204) begin n_fails++; $display("FAIL pend_then_seq got %h want 204", b32.pc); end
  endtask

  task automatic test_trap_priority();
    en = 0; tv = 1; tvec = 32'h80; rv = 1; rpc = 32'h300;
    tick();
    tv = 0; rv = 0;
    n_checks++; if (b32.pc !== 32'h80) begin n_fails++; $display("FAIL trap_prio got %h want 80", b32.pc); end
    en = 1; tick();
    n_checks++; if (b32.pc !== 32'h84 || b16.pc !== 32'h84) begin
      n_fails++; $display("FAIL trap_pend_clear got %h/%h want 84", b32.pc, b16.pc); end
  endtask

  task automatic test_misalign();
    logic [31:0] held;
    held = b32.pc;
    en = 1; rv = 1; rpc = 32'h102;
    tick();
    n_checks++; if (b32.misalign_err !== 1'b1 || b32.misalign_addr !== 32'h102) begin
      n_fails++; $display("FAIL mis_flag got %b/%h want 1/102", b32.misalign_err, b32.misalign_addr); end
    n_checks++; if (b32.pc !== held || b32.pc_valid !== 1'b0) begin
      n_fails++; $display("FAIL mis_hold got %h/%b want %h/0", b32.pc, b32.pc_valid, held); end
    n_checks++; if (b16.pc !== 32'h102 || b16.pc_valid !== 1'b1 || b16.misalign_err !== 1'b0) begin
      n_fails++; $display("FAIL mis_ialign16 got %h/%b/%b want 102/1/0", b16.pc, b16.pc_valid, b16.misalign_err); end
    rpc = 32'h500;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (b32.pc !== held || b32.pc_valid !== 1'b0 || b32.misalign_err !== 1'b0
                      || b32.misalign_addr !== 32'h102) begin
        n_fails++; $display("FAIL halt_ignore got %h/%b/%b/%h", b32.pc, b32.pc_valid, b32.misalign_err, b32.misalign_addr); end
    end
    rv = 0; tv = 1; tvec = 32'h43;
    tick();
    tv = 0;
    n_checks++; if (b32.pc !== 32'h40 || b32.pc_valid !== 1'b1) begin
      n_fails++; $display("FAIL halt_trap got %h/%b want 40/1", b32.pc, b32.pc_valid); end
    n_checks++; if (b16.pc !== 32'h42) begin n_fails++; $display("FAIL trap_align16 got %h want 42", b16.pc); end
  endtask

  task automatic test_reset_mid();
    en = 1; rv = 1; rpc = 32'h6;
    tick();
    rv = 0;
    n_checks++; if (b32.pc_valid !== 1'b0 || b16.pc !== 32'h6) begin
      n_fails++; $display("FAIL mid_halt got %b/%h want 0/6", b32.pc_valid, b16.pc); end
    rst = 1; tv = 1; tvec = 32'h80;
    tick();
    n_checks++; if (b32.pc !== 32'h0 || b32.pc_valid !== 1'b0 || b32.misalign_addr !== 32'h0) begin
      n_fails++; $display("FAIL mid_reset got %h/%b/%h want 0/0/0", b32.pc, b32.pc_valid, b32.misalign_addr); end
    rst = 0; tv = 0;
    tick();
    n_checks++; if (b32.pc !== 32'h0 || b32.pc_valid !== 1'b1) begin
      n_fails++; $display("FAIL mid_reboot got %h/%b want 0/1", b32.pc, b32.pc_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 49) == 0);
      en   = ($urandom_range(0, 3) != 0);
      rv   = ($urandom_range(0, 4) == 0);
      rpc  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      tv   = ($urandom_range(0, 11) == 0);
      tvec = $urandom;
      tick();
      n_checks++; if (b32.pc !== m32.pc || b32.pc_plus4 !== m32.pc + 32'd4) begin
        n_fails++; $display("FAIL rnd32_pc cyc %0d got %h/%h want %h", i, b32.pc, b32.pc_plus4, m32.pc); end
      n_checks++; if (b32.pc_valid !== (!m32.boot && !m32.halt) || b32.misalign_err !== m32.err
                      || b32.misalign_addr !== m32.maddr) begin
        n_fails++; $display("FAIL rnd32_status cyc %0d got %b/%b/%h want %b/%b/%h", i, b32.pc_valid,
                            b32.misalign_err, b32.misalign_addr, !m32.boot && !m32.halt, m32.err, m32.maddr); end
      n_checks++; if (b16.pc !== m16.pc || b16.pc_plus4 !== m16.pc + 32'd4) begin
        n_fails++; $display("FAIL rnd16_pc cyc %0d got %h/%h want %h", i, b16.pc, b16.pc_plus4, m16.pc); end
      n_checks++; if (b16.pc_valid !== (!m16.boot && !m16.halt) || b16.misalign_err !== m16.err
                      || b16.misalign_addr !== m16.maddr) begin
        n_fails++; $display("FAIL rnd16_status cyc %0d got %b/%b/%h want %b/%b/%h", i, b16.pc_valid,
                            b16.misalign_err, b16.misalign_addr, !m16.boot && !m16.halt, m16.err, m16.maddr); end
    end
    rst = 0; tv = 0; rv = 0;
  endtask

  initial begin
    m32 = '{pc: 32'h0, boot: 1, halt: 0, pend: 0, pend_pc: 32'h0, err: 0, maddr: 32'h0};
    m16 = m32;
    @(negedge clk);
    test_reset();
    test_stall_wrap();
    test_redirect_stall();
    test_trap_priority();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
